// File: rtl/node_elastic_buf.sv
// node_elastic_buf: DEPTH-entry circular elastic buffer between two valid/ready nodes, upstream ready from a flop.
// Defining NODE_ELASTIC_STATS_EN adds occupancy and high-water-mark outputs.
module node_elastic_buf #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_valid_in,
  output logic             up_ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             dn_valid_out,
  input  logic             dn_ready_in
`ifdef NODE_ELASTIC_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             ready_q;

  logic empty;
  logic bypass_path;
  logic up_fire;
  logic dn_fire;
  logic push;
  logic pop;

  assign empty       = (count == '0);
  assign bypass_path = (BYPASS != 0) && empty;

  assign up_ready_out = ready_q;
  assign dn_valid_out = bypass_path ? up_valid_in : !empty;
  assign data_out     = bypass_path ? data_in : mem[rd_ptr];

  assign up_fire = up_valid_in & ready_q;
  assign dn_fire = dn_valid_out & dn_ready_in;

  // A bypassed beat consumed in the same cycle never touches storage.
  assign push = up_fire & ~(bypass_path & dn_ready_in);
  assign pop  = dn_fire & ~bypass_path;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count   <= count_next;
      ready_q <= (count_next < CW'(DEPTH));
    end
  end

  // Storage is deliberately left unreset; it is only observed behind dn_valid_out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

`ifdef NODE_ELASTIC_STATS_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (count_next > hwm_q) begin
      hwm_q <= count_next;
    end
  end

  assign occupancy = count;
  assign hwm       = hwm_q;
`endif

endmodule

// File: tb/tb_node_elastic_buf.sv
// Scoreboard bench for node_elastic_buf: three configurations (D2/B0, D3/B0, D2/B1) share random and directed stimulus.
// Each configuration keeps its own reference queue and occupancy model.
module tb_node_elastic_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        uv;
  logic        dr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D  = (g == 1) ? 3 : 2;
    localparam int B  = (g == 2) ? 1 : 0;
    localparam int CW = $clog2(D + 1);

    logic        rdy;
    logic        vld;
    logic [31:0] dout;
    logic [31:0] q[$];
    int          occ = 0;
    int          hwm_m = 0;
    logic        exp_rdy = 1'b0;
`ifdef NODE_ELASTIC_STATS_EN
    logic [CW-1:0] occ_o;
    logic [CW-1:0] hwm_o;
`endif

    node_elastic_buf #(.WIDTH(32), .DEPTH(D), .BYPASS(B)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (din),
      .up_valid_in (uv),
      .up_ready_out(rdy),
      .data_out    (dout),
      .dn_valid_out(vld),
      .dn_ready_in (dr)
`ifdef NODE_ELASTIC_STATS_EN
      ,
      .occupancy   (occ_o),
      .hwm         (hwm_o)
`endif
    );

    // Issue side: every accepted beat is expected to emerge later, in order.
    always @(negedge clk) begin
      if (rst_n && uv && rdy) q.push_back(din);
    end

    // Monitor: compares handshake outputs to the occupancy model and pops the scoreboard.
    always @(negedge clk) begin
      #1;
      if (!rst_n) begin
        chk($sformatf("u%0d rst ready", g), rdy, 0);
        chk($sformatf("u%0d rst valid", g), vld, (B != 0) ? uv : 1'b0);
        q.delete();
        occ = 0;
        hwm_m = 0;
        exp_rdy = 1'b0;
      end else begin
        int up_f;
        int dn_f;
        up_f = (uv && rdy) ? 1 : 0;
        dn_f = (vld && dr) ? 1 : 0;
        chk($sformatf("u%0d ready", g), rdy, exp_rdy);
        chk($sformatf("u%0d valid", g), vld, (occ != 0) || ((B != 0) && uv));
`ifdef NODE_ELASTIC_STATS_EN
        chk($sformatf("u%0d occupancy", g), 32'(occ_o), occ);
        chk($sformatf("u%0d hwm", g), 32'(hwm_o), hwm_m);
`endif
        if (vld) begin
          if (q.size() == 0) begin
            chk($sformatf("u%0d spurious beat", g), vld, 0);
          end else if (dr) begin
            chk($sformatf("u%0d data", g), dout, q.pop_front());
          end else begin
            chk($sformatf("u%0d held data", g), dout, q[0]);
          end
        end
        occ = occ + up_f - dn_f;
        if (occ > D) chk($sformatf("u%0d overflow", g), occ, D);
        if (occ > hwm_m) hwm_m = occ;
        exp_rdy = (occ < D);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    uv = 1'b0;
    dr = 1'b0;
    din = '0;
    #2;
    chk("u0 ready under reset", u[0].rdy, 0);
    chk("u0 valid under reset", u[0].vld, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("u0 ready after release", u[0].rdy, 1);

    // Stream 1..8 at full rate; the first beat must appear one cycle later.
    dr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      uv = 1'b1;
      din = 32'(i);
      if (i == 1) begin
        #3;
        chk("u0 zero-latency absent", u[0].vld, 0);
      end
      if (i == 2) begin
        #3;
        chk("u0 first beat valid", u[0].vld, 1);
        chk("u0 first beat data", u[0].dout, 32'h1);
      end
      cyc(1);
    end
    uv = 1'b0;
    cyc(3);

    // Stall: A and B fill the depth-2 buffer, C waits for space.
    dr = 1'b0;
    uv = 1'b1;
    din = 32'hA;
    cyc(1);
    din = 32'hB;
    cyc(1);
    din = 32'hC;
    cyc(1);
    chk("u0 ready low when full", u[0].rdy, 0);
    cyc(2);
    dr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #3;
      if (u[0].rdy) break;
      cyc(1);
    end
    cyc(1);
    uv = 1'b0;
    cyc(4);

    // Bypass: empty buffer passes the beat through combinationally.
    uv = 1'b1;
    din = 32'h55;
    #2;
    chk("u2 bypass valid", u[2].vld, 1);
    chk("u2 bypass data", u[2].dout, 32'h55);
    cyc(1);
    uv = 1'b0;
    cyc(3);

    // Reset with two beats buffered: outputs drop immediately, nothing resurfaces.
    dr = 1'b0;
    uv = 1'b1;
    din = 32'h77;
    cyc(1);
    din = 32'h78;
    cyc(1);
    uv = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("u0 valid on reset", u[0].vld, 0);
    chk("u0 ready on reset", u[0].rdy, 0);
    cyc(2);
    rst_n = 1'b1;
    dr = 1'b1;
    cyc(4);

    for (int i = 0; i < 10000; i++) begin
      uv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 4) > 1);
      din = $urandom;
      cyc(1);
    end

    uv = 1'b0;
    dr = 1'b1;
    cyc(10);
    chk("u0 drained", u[0].q.size(), 0);
    chk("u1 drained", u[1].q.size(), 0);
    chk("u2 drained", u[2].q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
